// File: rtl/async_fifo_pkg.sv
// Shared definitions for the async FIFO pointer controllers: default sizes
// and the Gray/binary conversions used on both sides of the clock crossing.
package async_fifo_pkg;

  localparam int ADDR_W_DEF      = 3;
  localparam int SYNC_STAGES_DEF = 2;

  // Widest pointer any instance may use (ADDR_W up to 12, plus the wrap bit).
  // Narrower pointers are zero-extended into this width, which leaves both
  // conversions exact for every legal width.
  localparam int PTR_W_MAX = 13;

  typedef logic [PTR_W_MAX-1:0] ptrMax_t;

  function automatic ptrMax_t bin2gray(input ptrMax_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptrMax_t gray2bin(input ptrMax_t gray);
    ptrMax_t bin;
    bin = '0;
    bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock
// domain; shared by the write- and read-side pointer controllers.
module gray_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/wr_ptr_ctrl.sv
// Write-side pointer and flag controller of the async FIFO: owns the write
// pointer, watches the synchronised read pointer and raises full/level flags.
module wr_ptr_ctrl
  import async_fifo_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int AFULL_THRESH = 6,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
  input  logic              wclk,
  input  logic              wr_rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  input  logic              ovf_clr,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wrt_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow,
  output logic              overflow_sticky
);

  localparam int PTR_W = ADDR_W + 1;
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0] ptrBin_q, ptrBin_d;
  logic [PTR_W-1:0] ptrGray_q, ptrGray_d;
  logic [PTR_W-1:0] fill_q, fill_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;
  logic             wrAck;
  logic [PTR_W-1:0] rdGraySync;
  logic [PTR_W-1:0] rdBin;

  gray_sync #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk_i (wclk),
    .rst_i (wr_rst),
    .d_i   (rd_ptr_gray),
    .q_o   (rdGraySync)
  );

  // Full compares Gray codes directly: the pointers are one lap apart when
  // the two top bits differ and the rest match. Because the read pointer is
  // seen late, the flags can only err towards "more full".
  always_comb begin
    wrAck     = wr_en & ~full_q & ~wr_rst;
    ptrBin_d  = ptrBin_q + PTR_W'(wrAck);
    ptrGray_d = PTR_W'(bin2gray(PTR_W_MAX'(ptrBin_d)));
    rdBin     = PTR_W'(gray2bin(PTR_W_MAX'(rdGraySync)));
    fill_d    = ptrBin_d - rdBin;
    full_d    = (ptrGray_d == {~rdGraySync[ADDR_W:ADDR_W-1], rdGraySync[ADDR_W-2:0]});
    afull_d   = (fill_d >= AFULL_LVL);
    ovf_d     = wr_en & full_q;
    sticky_d  = ovf_d | (sticky_q & ~ovf_clr);
  end

  always_ff @(posedge wclk or posedge wr_rst) begin
    if (wr_rst) begin
      ptrBin_q  <= '0;
      ptrGray_q <= '0;
      fill_q    <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      ptrBin_q  <= ptrBin_d;
      ptrGray_q <= ptrGray_d;
      fill_q    <= fill_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
      sticky_q  <= sticky_d;
    end
  end

  assign wr_ack          = wrAck;
  assign wr_addr         = ptrBin_q[ADDR_W-1:0];
  assign wrt_ptr_gray    = ptrGray_q;
  assign full            = full_q;
  assign almost_full     = afull_q;
  assign wr_count        = fill_q;
  assign overflow        = ovf_q;
  assign overflow_sticky = sticky_q;

endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// Scoreboard bench for wr_ptr_ctrl (ADDR_W=3, AFULL_THRESH=6, SYNC_STAGES=2):
// the driver queues expected outputs per cycle, a monitor checks each negedge.
module tb_wr_ptr_ctrl;

  typedef struct {
    int         tag;
    logic       ack;
    logic [2:0] addr;
    logic       full;
    logic       afull;
    logic [3:0] cnt;
    logic       ovf;
    logic       sticky;
    logic [3:0] gray;
  } exp_t;

  logic       wclk;
  logic       wr_rst;
  logic       wr_en;
  logic [3:0] rd_ptr_gray;
  logic       ovf_clr;
  logic       wr_ack;
  logic [2:0] wr_addr;
  logic [3:0] wrt_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] wr_count;
  logic       overflow;
  logic       overflow_sticky;

  exp_t       expQ[$];
  logic [2:0] addrQ[$];
  int         nCmp;
  int         nFail;
  int         stepTag;
  logic       grayChk;

  wr_ptr_ctrl #(
    .ADDR_W       (3),
    .AFULL_THRESH (6),
    .SYNC_STAGES  (2)
  ) dut (
    .wclk            (wclk),
    .wr_rst          (wr_rst),
    .wr_en           (wr_en),
    .rd_ptr_gray     (rd_ptr_gray),
    .ovf_clr         (ovf_clr),
    .wr_ack          (wr_ack),
    .wr_addr         (wr_addr),
    .wrt_ptr_gray    (wrt_ptr_gray),
    .full            (full),
    .almost_full     (almost_full),
    .wr_count        (wr_count),
    .overflow        (overflow),
    .overflow_sticky (overflow_sticky)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  function automatic logic [3:0] tbGray(input logic [3:0] b);
    return b ^ {1'b0, b[3:1]};
  endfunction

  function automatic exp_t mkExp(input logic ack, input logic [2:0] addr,
                                 input logic fl, input logic af, input logic [3:0] cnt,
                                 input logic ovf, input logic st, input logic [3:0] gray);
    exp_t e;
    e.tag = 0; e.ack = ack; e.addr = addr; e.full = fl; e.afull = af;
    e.cnt = cnt; e.ovf = ovf; e.sticky = st; e.gray = gray;
    return e;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] req);
    nCmp++;
    if (act !== req) begin
      nFail++;
      $display("[TB] FAIL %s@%0d: actual=%0h required=%0h", nm, tag, act, req);
    end
  endtask

  // Inputs change 1 time unit after the edge; the expectation covers what the
  // monitor will see at the following negedge.
  task automatic applyStimulus(input logic rst, input logic en, input logic clr,
                               input logic [3:0] rdg, input exp_t e);
    @(posedge wclk);
    #1;
    wr_rst      = rst;
    wr_en       = en;
    ovf_clr     = clr;
    rd_ptr_gray = rdg;
    stepTag++;
    e.tag = stepTag;
    expQ.push_back(e);
    if (e.ack) addrQ.push_back(e.addr);
  endtask

  task automatic checkOutput(input exp_t e);
    chk("wr_ack",          e.tag, 32'(wr_ack),          32'(e.ack));
    chk("full",            e.tag, 32'(full),            32'(e.full));
    chk("almost_full",     e.tag, 32'(almost_full),     32'(e.afull));
    chk("wr_count",        e.tag, 32'(wr_count),        32'(e.cnt));
    chk("overflow",        e.tag, 32'(overflow),        32'(e.ovf));
    chk("overflow_sticky", e.tag, 32'(overflow_sticky), 32'(e.sticky));
    chk("wrt_ptr_gray",    e.tag, 32'(wrt_ptr_gray),    32'(e.gray));
    chk("wr_addr",         e.tag, 32'(wr_addr),         32'(e.addr));
  endtask

  // Monitor: flag snapshots every cycle, plus the accepted-address stream
  // whenever the DUT acknowledges a write.
  initial begin
    exp_t       e;
    logic [3:0] prevGray;
    logic [2:0] a;
    prevGray = '0;
    forever begin
      @(negedge wclk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
        if (grayChk) chk("gray_one_bit", e.tag, 32'($countones(prevGray ^ wrt_ptr_gray) <= 1), 32'd1);
      end
      if (wr_ack === 1'b1) begin
        if (addrQ.size() == 0) begin
          chk("unexpected_ack", stepTag, 32'd1, 32'd0);
        end else begin
          a = addrQ.pop_front();
          chk("ack_addr", stepTag, 32'(wr_addr), 32'(a));
        end
      end
      prevGray = wrt_ptr_gray;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] wp, s1, s2, rdIn, nxt, fill;
    logic       mFull, mAfull, mOvf, mSticky, lastEn, en, ack;
    logic [3:0] mCnt, mGray;
    int         nWr;
    int         cyc;

    nCmp = 0; nFail = 0; stepTag = 0; grayChk = 1'b0;
    wr_rst = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0; rd_ptr_gray = '0;

    // Reset, a short burst, then reset asserted mid-burst.
    applyStimulus(1, 1, 0, 4'd0, mkExp(0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 0, 4'd0, mkExp(1, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(0, 1, 0, 4'd0, mkExp(1, 1, 0, 0, 1, 0, 0, 4'd1));
    applyStimulus(0, 1, 0, 4'd0, mkExp(1, 2, 0, 0, 2, 0, 0, 4'd3));
    applyStimulus(1, 1, 0, 4'd0, mkExp(0, 0, 0, 0, 0, 0, 0, 0));
    applyStimulus(1, 0, 0, 4'd0, mkExp(0, 0, 0, 0, 0, 0, 0, 0));

    // Fill: eight writes with the read pointer parked at 0.
    applyStimulus(0, 1, 0, 4'd0, mkExp(1, 0, 0, 0, 4'd0, 0, 0, 4'd0));
    applyStimulus(0, 1, 0, 4'd0, mkExp(1, 1, 0, 0, 4'd1, 0, 0, 4'd1));
    applyStimulus(0, 1, 0, 4'd0, mkExp(1, 2, 0, 0, 4'd2, 0, 0, 4'd3));
    applyStimulus(0, 1, 0, 4'd0, mkExp(1, 3, 0, 0, 4'd3, 0, 0, 4'd2));
    applyStimulus(0, 1, 0, 4'd0, mkExp(1, 4, 0, 0, 4'd4, 0, 0, 4'd6));
    applyStimulus(0, 1, 0, 4'd0, mkExp(1, 5, 0, 0, 4'd5, 0, 0, 4'd7));
    applyStimulus(0, 1, 0, 4'd0, mkExp(1, 6, 0, 1, 4'd6, 0, 0, 4'd5));
    applyStimulus(0, 1, 0, 4'd0, mkExp(1, 7, 0, 1, 4'd7, 0, 0, 4'd4));

    // Overflow: three rejected writes, then a rejected write alongside ovf_clr.
    applyStimulus(0, 1, 0, 4'd0, mkExp(0, 0, 1, 1, 4'd8, 0, 0, 4'd12));
    applyStimulus(0, 1, 0, 4'd0, mkExp(0, 0, 1, 1, 4'd8, 1, 1, 4'd12));
    applyStimulus(0, 1, 0, 4'd0, mkExp(0, 0, 1, 1, 4'd8, 1, 1, 4'd12));
    applyStimulus(0, 1, 1, 4'd0, mkExp(0, 0, 1, 1, 4'd8, 1, 1, 4'd12));
    applyStimulus(0, 0, 1, 4'd0, mkExp(0, 0, 1, 1, 4'd8, 1, 1, 4'd12));
    applyStimulus(0, 0, 0, 4'd0, mkExp(0, 0, 1, 1, 4'd8, 0, 0, 4'd12));

    // Drain visibility: read pointer jumps to 2, seen three edges later.
    applyStimulus(0, 0, 0, 4'd3, mkExp(0, 0, 1, 1, 4'd8, 0, 0, 4'd12));
    applyStimulus(0, 0, 0, 4'd3, mkExp(0, 0, 1, 1, 4'd8, 0, 0, 4'd12));
    applyStimulus(0, 0, 0, 4'd3, mkExp(0, 0, 1, 1, 4'd8, 0, 0, 4'd12));
    applyStimulus(0, 0, 0, 4'd3, mkExp(0, 0, 0, 1, 4'd6, 0, 0, 4'd12));

    // Wrap: writes interleaved with a trailing read pointer, tracked by a
    // cycle model built from the flag definitions (fill = wptr - synced rptr).
    wp = 4'd8; s1 = 4'd2; s2 = 4'd2; rdIn = 4'd2;
    mFull = 0; mAfull = 1; mCnt = 4'd6; mGray = 4'd12; mOvf = 0; mSticky = 0;
    lastEn = 0; nWr = 0; cyc = 0;
    grayChk = 1'b1;
    while (nWr < 40 && cyc < 200) begin
      ack     = lastEn & ~mFull;
      nxt     = wp + 4'(ack);
      fill    = nxt - s2;
      mOvf    = lastEn & mFull;
      mSticky = mOvf | mSticky;
      mFull   = (fill == 4'd8);
      mCnt    = fill;
      mAfull  = (fill >= 4'd6);
      mGray   = tbGray(nxt);
      s2      = s1;
      s1      = rdIn;
      wp      = nxt;
      en      = ((cyc % 4) != 3);
      if (4'(wp - rdIn) > 4'd2) rdIn = rdIn + 4'd1;
      if (en & ~mFull) nWr++;
      applyStimulus(0, en, 0, tbGray(rdIn),
                    mkExp(en & ~mFull, wp[2:0], mFull, mAfull, mCnt, mOvf, mSticky, mGray));
      lastEn = en;
      cyc++;
    end
    chk("wrap_writes", stepTag, 32'(nWr), 32'd40);

    @(posedge wclk);
    #1;
    wr_en = 1'b0;
    grayChk = 1'b0;
    repeat (2) @(negedge wclk);
    #1;
    chk("exp_queue_drained", stepTag, 32'(expQ.size()), 32'd0);
    chk("ack_queue_drained", stepTag, 32'(addrQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/wr_ptr_ctrl.md
# wr_ptr_ctrl

Parametrised write-side pointer and flag controller for the async FIFO, running entirely in the write clock domain. It keeps a binary and Gray-coded write pointer and synchronises the read pointer's Gray code into `wclk`. From these it produces registered full, almost-full, fill-level and overflow indications. It sits between the write client and the dual-port RAM, and exports its Gray pointer to the read-side controller.

## Interface
- `ADDR_W`, default 3: RAM address width; depth = 2**ADDR_W; legal range 2..12.
- `AFULL_THRESH`, default 6: fill level at or above which `almost_full` asserts; legal range 1..2**ADDR_W.
- `SYNC_STAGES`, default 2: flop stages on the incoming read pointer; must be >= 2.
- `wclk`  in  1  write clock; the only clock of the block.
- `wr_rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  write request from the client.
- `rd_ptr_gray`  in  ADDR_W+1  read pointer, Gray coded, from the read domain; asynchronous to `wclk`.
- `ovf_clr`  in  1  clears `overflow_sticky`.
- `wr_ack`  out  ADDR_W... see below; 1 bit: write accepted this cycle; also the RAM write strobe.
- `wr_addr`  out  ADDR_W  RAM write address.
- `wrt_ptr_gray`  out  ADDR_W+1  registered Gray write pointer, sent to the read domain.
- `full`  out  1  FIFO full.
- `almost_full`  out  1  fill level >= AFULL_THRESH.
- `wr_count`  out  ADDR_W+1  fill level as seen from the write side (0..2**ADDR_W).
- `overflow`  out  1  one-cycle pulse on a write request rejected because the FIFO is full.
- `overflow_sticky`  out  1  latched overflow.

## Operation
- **Accept rule.** `wr_ack = wr_en & ~full`, combinational. The pointer advances only on `wr_ack`.
- **Binary pointer.** `ptr_bin` is ADDR_W+1 bits. `ptr_next = ptr_bin + wr_ack`, modulo 2**(ADDR_W+1); wrap from all-ones to 0 is silent.
- **Address.** `wr_addr = ptr_bin[ADDR_W-1:0]`.
- **Gray pointer.** `wrt_ptr_gray <= bin2gray(ptr_next)` every cycle.
- **Read pointer path.** `rd_ptr_gray` passes through SYNC_STAGES flops to give `rq`. `rq` is converted to binary `rd_bin` combinationally.
- **Full.** `full <= (bin2gray(ptr_next) == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]})`.
- **Fill level.** `wr_count <= ptr_next - rd_bin`, modulo 2**(ADDR_W+1).
- **Almost full.** `almost_full <= (ptr_next - rd_bin) >= AFULL_THRESH`.
- **Overflow.** `overflow <= wr_en & full`. `overflow_sticky` sets on the same condition and clears on `ovf_clr`. When both occur in one cycle, set wins.
- **Reset values.** All registers, including the synchroniser, reset to 0. Hence `full`, `almost_full`, `wr_count`, `overflow`, `overflow_sticky`, `wrt_ptr_gray` and `wr_addr` all read 0 during and after reset.
- **Reset mid-operation.** Reset clears everything immediately and asynchronously. `wr_ack` is forced low while `wr_rst` is high.

## Timing
- `wr_ack` is same-cycle, with zero latency from `wr_en`.
- `full`, `almost_full`, `wr_count` and `wrt_ptr_gray` reflect a write in the cycle after its `wr_ack`. The write that fills the FIFO therefore raises `full` on the next edge.
- A read-pointer change reaches `full` and `wr_count` after SYNC_STAGES+1 `wclk` edges. The flags are pessimistic (full stays asserted longer) and never optimistic.
- **Simultaneous write and read-pointer update.** Both are applied in the same computation of `ptr_next - rd_bin`.
- **Rejected write.** A write attempted while full:
  - leaves the pointer unchanged;
  - raises `overflow` for exactly one cycle per rejected cycle.
- **Gray output.** `wrt_ptr_gray` changes by at most one bit per `wclk` cycle.

## Structure
- Shared package `async_fifo_pkg` holds:
  - the functions `bin2gray` and `gray2bin`, parametrised by width;
  - the default constants for ADDR_W and SYNC_STAGES, shared with the read-side controller.
- One sub-module, `gray_sync`: a SYNC_STAGES-deep flop chain of ADDR_W+1 bits with async active-high reset to 0. The read-side controller reuses it.

## Test plan
All scenarios use ADDR_W=3, AFULL_THRESH=6, SYNC_STAGES=2.
1. **Reset.** Assert `wr_rst` mid-burst.
   - Outputs go to 0 immediately.
   - The first write after release has `wr_addr=0`.
2. **Fill.** Hold `rd_ptr_gray=0` and write 8 consecutive cycles.
   - `wr_ack` is high on all 8 writes.
   - `almost_full` rises after the 6th write.
   - `full` rises after the 8th write.
   - `wr_count` reads 8.
3. **Overflow.** Continue `wr_en` for 3 cycles after scenario 2.
   - `wr_ack` stays 0; `wr_addr` stays 0; the pointer does not move.
   - `overflow` pulses 3 cycles.
   - `overflow_sticky` is 1 until `ovf_clr`.
4. **Drain visibility.** From full, set `rd_ptr_gray=bin2gray(2)`.
   - `full` drops and `wr_count` reads 6 exactly 3 edges later.
   - `almost_full` stays 1.
5. **Wrap.** Run 40 writes interleaved with read-pointer advances so the FIFO is never full.
   - `ptr_bin` wraps 15→0.
   - `wrt_ptr_gray` changes by one bit per step.
   - `wr_count` stays correct across the wrap.
6. **Simultaneous set/clear.** Raise `ovf_clr` in a cycle with a rejected write: `overflow_sticky` stays 1.
